// File: rtl/dp_bram_be_pipe.sv
// True dual-port BRAM with byte enables, selectable read-during-write, 1/2-cycle
// read latency with valid pulses, out-of-range/collision flags and a post-reset clear.
module dp_bram_be_pipe #(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 12,
    parameter int MEM_SIZE       = 3840,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NBYTES        = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr0,
    input  logic              ce0,
    input  logic [NBYTES-1:0] we0,
    input  logic [DWIDTH-1:0] d0,
    output logic [DWIDTH-1:0] q0,
    output logic              q0_valid,
    input  logic [AWIDTH-1:0] addr1,
    input  logic              ce1,
    input  logic [NBYTES-1:0] we1,
    input  logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] q1,
    output logic              q1_valid,
    output logic              init_busy,
    output logic              collision,
    output logic              oob_err
);
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [AWIDTH:0]   LP_SIZE   = (AWIDTH+1)'(MEM_SIZE);
    localparam logic [AWIDTH-1:0] LP_LAST   = AWIDTH'(MEM_SIZE - 1);
    localparam state_t            LP_RST_ST = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    state_t              r_state, w_state_nxt;
    logic [AWIDTH-1:0]   r_clr_cnt;
    logic [DWIDTH-1:0]   r_mem [0:MEM_SIZE-1];
    logic                r_coll, r_oob;
    logic                w_ready;

    logic [AWIDTH-1:0]   w_addr    [2];
    logic                w_ce      [2];
    logic [NBYTES-1:0]   w_we      [2];
    logic [DWIDTH-1:0]   w_d       [2];
    logic                w_act     [2];
    logic                w_inr     [2];
    logic                w_wr      [2];
    logic [DWIDTH-1:0]   w_old     [2];
    logic [DWIDTH-1:0]   w_new     [2];
    logic                w_rsp_vld [2];
    logic [DWIDTH-1:0]   w_rsp_dat [2];
    logic [DWIDTH-1:0]   w_q       [2];
    logic                w_qv      [2];

    function automatic logic [DWIDTH-1:0] f_merge(input logic [DWIDTH-1:0] old,
                                                  input logic [DWIDTH-1:0] dat,
                                                  input logic [NBYTES-1:0] be);
        logic [DWIDTH-1:0] res;
        res = old;
        for (int b = 0; b < NBYTES; b++)
            if (be[b]) res[8*b +: 8] = dat[8*b +: 8];
        return res;
    endfunction

    assign w_addr[0] = addr0;  assign w_addr[1] = addr1;
    assign w_ce[0]   = ce0;    assign w_ce[1]   = ce1;
    assign w_we[0]   = we0;    assign w_we[1]   = we1;
    assign w_d[0]    = d0;     assign w_d[1]    = d1;

    assign w_ready   = (r_state == S_READY);
    assign init_busy = ~w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LP_RST_ST;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_cnt == LP_LAST) w_state_nxt = S_READY;
    end

    // Port 1 lanes are written after port 0 lanes, so port 1 wins shared lanes.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (w_act[p] && w_inr[p])
                    for (int b = 0; b < NBYTES; b++)
                        if (w_we[p][b]) r_mem[w_addr[p]][8*b +: 8] <= w_d[p][8*b +: 8];
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_port
            logic [DWIDTH-1:0] r_q_s1;
            logic              r_v_s1;

            // Reads sample the array before this cycle's writes: read-first across ports.
            assign w_act[gp]     = w_ready & w_ce[gp];
            assign w_inr[gp]     = ({1'b0, w_addr[gp]} < LP_SIZE);
            assign w_wr[gp]      = |w_we[gp];
            assign w_old[gp]     = w_inr[gp] ? r_mem[w_addr[gp]] : '0;
            assign w_new[gp]     = w_inr[gp] ? f_merge(w_old[gp], w_d[gp], w_we[gp]) : '0;
            assign w_rsp_vld[gp] = w_act[gp] & (~w_wr[gp] | (RDW_MODE != 0));
            assign w_rsp_dat[gp] = (w_wr[gp] && RDW_MODE == 2) ? w_new[gp] : w_old[gp];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_s1 <= '0;
                    r_v_s1 <= 1'b0;
                end else begin
                    r_v_s1 <= w_rsp_vld[gp];
                    if (w_rsp_vld[gp]) r_q_s1 <= w_rsp_dat[gp];
                end
            end

            if (RD_LAT == 2) begin : g_lat2
                logic [DWIDTH-1:0] r_q_s2;
                logic              r_v_s2;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q_s2 <= '0;
                        r_v_s2 <= 1'b0;
                    end else begin
                        r_v_s2 <= r_v_s1;
                        if (r_v_s1) r_q_s2 <= r_q_s1;
                    end
                end
                assign w_q[gp]  = r_q_s2;
                assign w_qv[gp] = r_v_s2;
            end else begin : g_lat1
                assign w_q[gp]  = r_q_s1;
                assign w_qv[gp] = r_v_s1;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll <= 1'b0;
            r_oob  <= 1'b0;
        end else begin
            r_oob  <= w_ready & ((w_ce[0] & ~w_inr[0]) | (w_ce[1] & ~w_inr[1]));
            r_coll <= w_act[0] & w_act[1] & w_inr[0] & w_inr[1]
                    & (w_addr[0] == w_addr[1]) & (w_wr[0] | w_wr[1]);
        end
    end

    assign q0        = w_q[0];
    assign q0_valid  = w_qv[0];
    assign q1        = w_q[1];
    assign q1_valid  = w_qv[1];
    assign collision = r_coll;
    assign oob_err   = r_oob;

endmodule

// File: tb/tb_dp_bram_be_pipe.sv
// Bench for dp_bram_be_pipe: three instances (lat1/NO_CHANGE, lat2/READ_FIRST,
// lat1/WRITE_FIRST) share stimulus; a reference model feeds per-port scoreboards.
module tb_dp_bram_be_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr0, addr1;
    logic        ce0, ce1;
    logic [3:0]  we0, we1;
    logic [31:0] d0, d1;

    logic [31:0] q0_o [3];
    logic [31:0] q1_o [3];
    logic        q0v_o [3];
    logic        q1v_o [3];
    logic        busy_o [3];
    logic        coll_o [3];
    logic        oob_o [3];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [3][2][$];
    int          collq [$];
    int          oobq [$];
    logic [31:0] mdl [3840];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dp_bram_be_pipe #(.RD_LAT(1), .RDW_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_o[0]), .q0_valid(q0v_o[0]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_o[0]), .q1_valid(q1v_o[0]),
        .init_busy(busy_o[0]), .collision(coll_o[0]), .oob_err(oob_o[0]));

    dp_bram_be_pipe #(.RD_LAT(2), .RDW_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_o[1]), .q0_valid(q0v_o[1]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_o[1]), .q1_valid(q1v_o[1]),
        .init_busy(busy_o[1]), .collision(coll_o[1]), .oob_err(oob_o[1]));

    dp_bram_be_pipe #(.RD_LAT(1), .RDW_MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_o[2]), .q0_valid(q0v_o[2]),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_o[2]), .q1_valid(q1v_o[2]),
        .init_busy(busy_o[2]), .collision(coll_o[2]), .oob_err(oob_o[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] x,
                                           input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
        return (o & ~m) | (x & m);
    endfunction

    // One access cycle on both ports; expectations come from the model before it is updated.
    task automatic drive(input logic c0, input logic [3:0] w0, input logic [11:0] a0,
                         input logic [31:0] x0, input logic c1, input logic [3:0] w1,
                         input logic [11:0] a1, input logic [31:0] x1);
        logic        c [2];
        logic [3:0]  w [2];
        logic [11:0] a [2];
        logic [31:0] x [2];
        logic [31:0] old [2];
        logic [31:0] nw [2];
        bit          inr [2];
        ce0 = c0; we0 = w0; addr0 = a0; d0 = x0;
        ce1 = c1; we1 = w1; addr1 = a1; d1 = x1;
        c[0] = c0; w[0] = w0; a[0] = a0; x[0] = x0;
        c[1] = c1; w[1] = w1; a[1] = a1; x[1] = x1;
        for (int p = 0; p < 2; p++) begin
            inr[p] = (a[p] < 12'd3840);
            old[p] = inr[p] ? mdl[a[p]] : 32'h0;
            nw[p]  = inr[p] ? bmerge(old[p], x[p], w[p]) : 32'h0;
        end
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++)
                if (c[p] && (w[p] == 4'h0 || d != 0)) begin
                    exp_t e;
                    e.data = (w[p] != 4'h0 && d == 2) ? nw[p] : old[p];
                    e.due  = cyc + ((d == 1) ? 2 : 1);
                    sbq[d][p].push_back(e);
                end
        if ((c0 && !inr[0]) || (c1 && !inr[1])) oobq.push_back(cyc + 1);
        if (c0 && c1 && inr[0] && inr[1] && a0 == a1 && (w0 != 4'h0 || w1 != 4'h0))
            collq.push_back(cyc + 1);
        for (int p = 0; p < 2; p++)
            if (c[p] && inr[p]) mdl[a[p]] = bmerge(mdl[a[p]], x[p], w[p]);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 12'd0, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.D%0d.q0", d), q0_o[d], 32'h0);
            chk($sformatf("rst.D%0d.q1", d), q1_o[d], 32'h0);
            chk($sformatf("rst.D%0d.q0_valid", d), q0v_o[d], 32'h0);
            chk($sformatf("rst.D%0d.q1_valid", d), q1v_o[d], 32'h0);
            chk($sformatf("rst.D%0d.collision", d), coll_o[d], 32'h0);
            chk($sformatf("rst.D%0d.oob_err", d), oob_o[d], 32'h0);
            chk($sformatf("rst.D%0d.init_busy", d), busy_o[d], 32'h1);
        end
    endtask

    // Counts busy cycles after release; optionally fires a port access mid-clear.
    task automatic clear_wait(input bit inject);
        int n = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy_o[0]) break;
            n++;
            if (inject && n == 200) begin
                ce0 = 1'b1; we0 = 4'hF; addr0 = 12'd5; d0 = 32'hDEADBEEF;
                ce1 = 1'b1; we1 = 4'h0; addr1 = 12'd6;
            end
            if (n == 201) begin
                ce0 = 1'b0; ce1 = 1'b0; we0 = 4'h0;
            end
        end
        chk("clear_cycles", n, 32'd3840);
        chk("D1.init_busy_done", busy_o[1], 32'h0);
        chk("D2.init_busy_done", busy_o[2], 32'h0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        logic        v;
        logic [31:0] q;
        bit          e, ec, eo;
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++) begin
                v = (p == 0) ? q0v_o[d] : q1v_o[d];
                q = (p == 0) ? q0_o[d] : q1_o[d];
                e = (sbq[d][p].size() > 0) && (sbq[d][p][0].due == cyc);
                if (e || v) chk($sformatf("D%0d.q%0d_valid", d, p), v, e);
                if (e) begin
                    chk($sformatf("D%0d.q%0d_data", d, p), q, sbq[d][p][0].data);
                    void'(sbq[d][p].pop_front());
                end
            end
        ec = (collq.size() > 0) && (collq[0] == cyc);
        eo = (oobq.size() > 0) && (oobq[0] == cyc);
        for (int d = 0; d < 3; d++) begin
            if (ec || coll_o[d]) chk($sformatf("D%0d.collision", d), coll_o[d], ec);
            if (eo || oob_o[d]) chk($sformatf("D%0d.oob_err", d), oob_o[d], eo);
        end
        if (ec) void'(collq.pop_front());
        if (eo) void'(oobq.pop_front());
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int left;
        for (int i = 0; i < 3840; i++) mdl[i] = 32'h0;
        rst_n = 1'b0;
        ce0 = 1'b0; we0 = 4'h0; addr0 = 12'd0; d0 = 32'h0;
        ce1 = 1'b0; we1 = 4'h0; addr1 = 12'd0; d1 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst_n = 1'b1;
        clear_wait(1'b0);

        // cleared contents
        drive(1'b1, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd1919, 32'h0);
        drive(1'b1, 4'h0, 12'd3839, 32'h0, 1'b0, 4'h0, 12'd0, 32'h0);
        idle(3);

        // byte enables
        drive(1'b1, 4'hF, 12'd5, 32'hAABBCCDD, 1'b0, 4'h0, 12'd0, 32'h0);
        drive(1'b1, 4'h5, 12'd5, 32'h11223344, 1'b0, 4'h0, 12'd0, 32'h0);
        drive(1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd5, 32'h0);
        idle(3);

        // dual write collision, then same-address dual read (no collision)
        drive(1'b1, 4'h3, 12'd9, 32'h0000FFFF, 1'b1, 4'h6, 12'd9, 32'h12345678);
        drive(1'b1, 4'h0, 12'd9, 32'h0, 1'b1, 4'h0, 12'd9, 32'h0);
        idle(3);

        // read-during-write on one port
        drive(1'b1, 4'hF, 12'd3, 32'h1, 1'b0, 4'h0, 12'd0, 32'h0);
        drive(1'b1, 4'hF, 12'd3, 32'h2, 1'b0, 4'h0, 12'd0, 32'h0);
        drive(1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd3, 32'h0);
        idle(3);

        // out of range: single pulse per cycle even with both ports out
        drive(1'b1, 4'h0, 12'd3840, 32'h0, 1'b1, 4'hF, 12'd4000, 32'hDEADBEEF);
        idle(1);
        drive(1'b1, 4'h0, 12'd4095, 32'h0, 1'b1, 4'h0, 12'd3841, 32'h0);
        drive(1'b1, 4'h0, 12'd160, 32'h0, 1'b1, 4'h0, 12'd1952, 32'h0);
        idle(3);

        // back-to-back pipelined traffic with cross-port write/read collisions
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'hF, 12'(100 + i), $urandom, 1'b1, 4'h0, 12'(100 + i), 32'h0);
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'h0, 12'(100 + i), 32'h0, 1'b1, 4'h0, 12'(115 - i), 32'h0);
        idle(4);

        // reset mid-clear restarts; a mid-clear access is ignored
        drive(1'b1, 4'hF, 12'd0, 32'h5A5A5A5A, 1'b1, 4'hF, 12'd1919, 32'hA5A5A5A5);
        drive(1'b1, 4'hF, 12'd3839, 32'hC3C3C3C3, 1'b1, 4'h0, 12'd0, 32'h0);
        idle(4);
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midclear.init_busy", busy_o[0], 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_wait(1'b1);
        for (int i = 0; i < 3840; i++) mdl[i] = 32'h0;
        drive(1'b1, 4'h0, 12'd0, 32'h0, 1'b1, 4'h0, 12'd1919, 32'h0);
        drive(1'b1, 4'h0, 12'd3839, 32'h0, 1'b1, 4'h0, 12'd5, 32'h0);
        idle(4);

        left = collq.size() + oobq.size();
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++) left += sbq[d][p].size();
        chk("pending_expectations", left, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
